// File: rtl/laneswitch_mem.sv
// Dual-port memory responder for the lane switch mem_* outputs.
// After reset it clears itself word by word, then serves pipelined reads and writes.
module laneswitch_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int ADDR_RANGE   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_address0,
  input  logic [ADDR_WIDTH-1:0] mem_address1,
  input  logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_d1,
  output logic [DATA_WIDTH-1:0] mem_q0,
  output logic [DATA_WIDTH-1:0] mem_q1,
  input  logic                  mem_ce0,
  input  logic                  mem_ce1,
  input  logic                  mem_we0,
  input  logic                  mem_we1,
  output logic                  ready,
  output logic                  collision,
  output logic                  oob
);

  // state  | meaning
  // S_INIT | clearing mem[init_addr_q], port accesses ignored
  // S_RUN  | clear finished, ports active; left only through reset
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_WIDTH:0]   RANGE_W   = ADDR_RANGE[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_RANGE - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                    run, init_we;
  logic [DATA_WIDTH-1:0]   mem [ADDR_RANGE];

  logic                    in_rng0, in_rng1, acc0, acc1, wr0, wr1, coll;
  logic [1:0]              rd_v, src_v;
  logic [DATA_WIDTH-1:0]   rd_d [2];
  logic [DATA_WIDTH-1:0]   src_d [2];
  logic [DATA_WIDTH-1:0]   q0_q, q1_q;
  logic                    collision_q, oob_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == S_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == LAST_ADDR) state_d = S_RUN;
    end
  end

  always_comb begin
    run     = (state_q == S_RUN);
    init_we = (state_q == S_INIT);
    ready   = run;
  end

  assign in_rng0 = {1'b0, mem_address0} < RANGE_W;
  assign in_rng1 = {1'b0, mem_address1} < RANGE_W;
  assign acc0    = run & mem_ce0;
  assign acc1    = run & mem_ce1;
  assign wr0     = acc0 & mem_we0 & in_rng0;
  assign wr1     = acc1 & mem_we1 & in_rng1;
  assign coll    = wr0 & wr1 & (mem_address0 == mem_address1);
  assign rd_v    = {acc1 & ~mem_we1, acc0 & ~mem_we0};
  assign rd_d[0] = in_rng0 ? mem[mem_address0] : '0;
  assign rd_d[1] = in_rng1 ? mem[mem_address1] : '0;

  // Contents survive reset; only the INIT sweep clears them. Port 0 wins a same-address write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_we) begin
        mem[init_addr_q] <= '0;
      end else begin
        if (wr0)         mem[mem_address0] <= mem_d0;
        if (wr1 && !coll) mem[mem_address1] <= mem_d1;
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign src_v = rd_v;
      assign src_d = rd_d;
    end else begin : g_pipe
      logic [1:0]            pv_q [READ_LATENCY-1];
      logic [DATA_WIDTH-1:0] pd_q [READ_LATENCY-1][2];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < READ_LATENCY-1; s++) begin
            pv_q[s]    <= '0;
            pd_q[s][0] <= '0;
            pd_q[s][1] <= '0;
          end
        end else begin
          pv_q[0] <= rd_v;
          pd_q[0] <= rd_d;
          for (int s = 1; s < READ_LATENCY-1; s++) begin
            pv_q[s] <= pv_q[s-1];
            pd_q[s] <= pd_q[s-1];
          end
        end
      end
      assign src_v = pv_q[READ_LATENCY-2];
      assign src_d = pd_q[READ_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q0_q        <= '0;
      q1_q        <= '0;
      collision_q <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      if (src_v[0]) q0_q <= src_d[0];
      if (src_v[1]) q1_q <= src_d[1];
      collision_q <= coll;
      oob_q       <= (acc0 & ~in_rng0) | (acc1 & ~in_rng1);
    end
  end

  assign mem_q0    = q0_q;
  assign mem_q1    = q1_q;
  assign collision = collision_q;
  assign oob       = oob_q;

endmodule

// File: tb/tb_laneswitch_mem.sv
// Bench for laneswitch_mem: two instances (latency 2 / full range, latency 1 / 48 words)
// share stimulus; a reference memory model feeds per-port expected-read queues.
module tb_laneswitch_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        ce0, ce1, we0, we1;
  logic [31:0] qa0, qa1, qb0, qb1;
  logic        rdy_a, rdy_b, coll_a, coll_b, oob_a, oob_b;

  always #5 clk = ~clk;

  laneswitch_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .ADDR_RANGE(64), .READ_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .mem_address0(a0), .mem_address1(a1), .mem_d0(d0), .mem_d1(d1),
    .mem_q0(qa0), .mem_q1(qa1), .mem_ce0(ce0), .mem_ce1(ce1),
    .mem_we0(we0), .mem_we1(we1), .ready(rdy_a), .collision(coll_a), .oob(oob_a));

  laneswitch_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .ADDR_RANGE(48), .READ_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .mem_address0(a0), .mem_address1(a1), .mem_d0(d0), .mem_d1(d1),
    .mem_q0(qb0), .mem_q1(qb1), .mem_ce0(ce0), .mem_ce1(ce1),
    .mem_we0(we0), .mem_we1(we1), .ready(rdy_b), .collision(coll_b), .oob(oob_b));

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq [4][$];
  logic [31:0] model [2][64];
  int          rng [2] = '{64, 48};
  int          lat [2] = '{2, 1};
  string       qtag [4] = '{"q_a0", "q_a1", "q_b0", "q_b1"};
  logic [31:0] q_exp [4];
  logic        coll_exp [2];
  logic        oob_exp [2];
  int          cyc, init_cnt;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] obs_q(input int i);
    case (i)
      0:       return qa0;
      1:       return qa1;
      2:       return qb0;
      default: return qb1;
    endcase
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 4; i++) chk(qtag[i], obs_q(i), q_exp[i]);
    chk("ready_a", 32'(rdy_a), 32'(init_cnt >= rng[0]));
    chk("ready_b", 32'(rdy_b), 32'(init_cnt >= rng[1]));
    chk("collision_a", 32'(coll_a), 32'(coll_exp[0]));
    chk("collision_b", 32'(coll_b), 32'(coll_exp[1]));
    chk("oob_a", 32'(oob_a), 32'(oob_exp[0]));
    chk("oob_b", 32'(oob_b), 32'(oob_exp[1]));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      for (int d = 0; d < 2; d++)
        if (init_cnt < rng[d]) model[d][init_cnt] = '0;
      if (init_cnt < 64) init_cnt++;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      while (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
        e = sbq[i].pop_front();
        q_exp[i] = e.data;
      end
    end
    check_outputs();
    for (int d = 0; d < 2; d++) begin
      coll_exp[d] = 1'b0;
      oob_exp[d]  = 1'b0;
    end
  endtask

  task automatic apply(input logic c0, input logic w0, input logic [5:0] x0, input logic [31:0] y0,
                       input logic c1, input logic w1, input logic [5:0] x1, input logic [31:0] y1);
    exp_t e;
    logic ir0, ir1, wr0, wr1;
    ce0 = c0; we0 = w0; a0 = x0; d0 = y0;
    ce1 = c1; we1 = w1; a1 = x1; d1 = y1;
    for (int d = 0; d < 2; d++) begin
      if (init_cnt >= rng[d]) begin
        ir0 = int'(x0) < rng[d];
        ir1 = int'(x1) < rng[d];
        if (c0 && !w0) begin
          e.due = cyc + lat[d]; e.data = ir0 ? model[d][x0] : 32'h0;
          sbq[d*2].push_back(e);
        end
        if (c1 && !w1) begin
          e.due = cyc + lat[d]; e.data = ir1 ? model[d][x1] : 32'h0;
          sbq[d*2+1].push_back(e);
        end
        oob_exp[d]  = (c0 && !ir0) || (c1 && !ir1);
        wr0         = c0 && w0 && ir0;
        wr1         = c1 && w1 && ir1;
        coll_exp[d] = wr0 && wr1 && (x0 == x1);
        if (wr1) model[d][x1] = y1;
        if (wr0) model[d][x0] = y0;
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      apply(1'b0, 1'b1, 6'($urandom), $urandom, 1'b0, 1'b0, 6'($urandom), $urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      sbq[i].delete();
      q_exp[i] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      coll_exp[d] = 1'b0;
      oob_exp[d]  = 1'b0;
    end
    init_cnt = 0;
    check_outputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; init_cnt = 0;
    ce0 = 1'b0; ce1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 64; k++) model[d][k] = 'x;
    do_reset();

    // clear sweep with both ports hammering; accesses must be ignored until ready
    for (int i = 0; i < 64; i++)
      apply(1'b1, 1'b1, 6'(i), $urandom, 1'b1, 1'b0, 6'(63 - i), 32'h0);
    chk("ready_after_64", 32'(rdy_a), 32'h1);
    for (int i = 0; i < 64; i++)
      apply(1'b1, 1'b0, 6'(i), 32'h0, 1'b1, 1'b0, 6'(63 - i), 32'h0);
    idle(3);

    // write then read across ports
    apply(1'b1, 1'b1, 6'd5, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0, 32'h0);
    apply(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd5, 32'h0);
    idle(3);
    chk("q1_a5", qa1, 32'hA5A5A5A5);

    // same-address dual write: port 0 wins
    apply(1'b1, 1'b1, 6'd9, 32'h11, 1'b1, 1'b1, 6'd9, 32'h22);
    apply(1'b1, 1'b0, 6'd9, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    idle(3);

    // read-during-write returns old data
    apply(1'b1, 1'b1, 6'd3, 32'h7, 1'b0, 1'b0, 6'd0, 32'h0);
    apply(1'b1, 1'b0, 6'd3, 32'h0, 1'b1, 1'b1, 6'd3, 32'h8);
    apply(1'b1, 1'b0, 6'd3, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    idle(3);

    // ce low blocks everything
    apply(1'b0, 1'b1, 6'd7, 32'hDEAD, 1'b0, 1'b1, 6'd7, 32'hBEEF);
    apply(1'b1, 1'b0, 6'd7, 32'h0, 1'b1, 1'b0, 6'd7, 32'h0);
    idle(3);

    // out-of-range write/read (in range for the 64-word instance)
    apply(1'b1, 1'b1, 6'd50, 32'hFF, 1'b0, 1'b0, 6'd0, 32'h0);
    apply(1'b1, 1'b0, 6'd50, 32'h0, 1'b1, 1'b0, 6'd50, 32'h0);
    apply(1'b1, 1'b1, 6'd55, 32'h1, 1'b1, 1'b1, 6'd55, 32'h2);
    idle(2);
    for (int i = 0; i < 48; i++)
      apply(1'b1, 1'b0, 6'(i), 32'h0, 1'b1, 1'b0, 6'(47 - i), 32'h0);
    idle(3);

    // mixed traffic
    for (int k = 0; k < 300; k++)
      apply(1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0) ? 6'd50 : 6'($urandom_range(0, 15)), $urandom,
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0) ? 6'd52 : 6'($urandom_range(0, 15)), $urandom);
    idle(3);

    // reset with reads in flight, then again partway through the clear
    apply(1'b1, 1'b0, 6'd9, 32'h0, 1'b1, 1'b0, 6'd3, 32'h0);
    do_reset();
    for (int i = 0; i < 20; i++) idle(1);
    chk("init_progress", 32'(init_cnt), 32'd20);
    do_reset();
    for (int i = 0; i < 63; i++) idle(1);
    chk("ready_not_yet", 32'(rdy_a), 32'h0);
    idle(1);
    chk("ready_again", 32'(rdy_a), 32'h1);
    for (int i = 0; i < 64; i++)
      apply(1'b1, 1'b0, 6'(i), 32'h0, 1'b1, 1'b0, 6'(63 - i), 32'h0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
